// File: rtl/reg_bus_arbiter_if.sv
// Register write bus between the two masters (host, audio sequencer) and the arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface reg_bus_arbiter_if;
   logic        m0_req;
   logic [10:0] m0_address;
   logic [7:0]  m0_wdata;
   logic        m0_gnt;
   logic        m0_done;
   logic        m1_req;
   logic [10:0] m1_address;
   logic [7:0]  m1_wdata;
   logic        m1_gnt;
   logic        m1_done;
   logic [10:0] address;
   logic [7:0]  wdata;
   logic        xfc;
   logic        busy;

   modport slave (
      input  m0_req, m0_address, m0_wdata,
      input  m1_req, m1_address, m1_wdata,
      output m0_gnt, m0_done, m1_gnt, m1_done,
      output address, wdata, xfc, busy
   );

   modport master (
      output m0_req, m0_address, m0_wdata,
      output m1_req, m1_address, m1_wdata,
      input  m0_gnt, m0_done, m1_gnt, m1_done,
      input  address, wdata, xfc, busy
   );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Two-master arbiter for the trig_generator register write bus; registered xfc strobe plus idle gap.
// Define REG_ARB_FIXED_PRIO_EN for fixed priority (m0 wins ties); default is round-robin.
module reg_bus_arbiter #(
   parameter int XFC_CYCLES = 1,
   parameter int GAP_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   reg_bus_arbiter_if.slave   bus
);

   generate
      if (XFC_CYCLES < 1 || XFC_CYCLES > 15) begin : g_badXfc
         $error("reg_bus_arbiter: XFC_CYCLES must be 1..15");
      end
      if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_badGap
         $error("reg_bus_arbiter: GAP_CYCLES must be 1..15");
      end
   endgenerate

   localparam logic [3:0] XFC_LOAD = 4'(XFC_CYCLES - 1);
   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_XFER,
      ST_DONE,
      ST_GAP
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_winner;
   logic [10:0] r_address;
   logic [7:0]  r_wdata;
   logic        r_xfc;
   logic        r_busy;
   logic [1:0]  r_gnt;
   logic [1:0]  r_done;

   state_t      w_nextState;
   logic [3:0]  w_nextCnt;
   logic        w_nextWinner;
   logic [10:0] w_nextAddress;
   logic [7:0]  w_nextWdata;
   logic        w_nextXfc;
   logic [1:0]  w_nextGnt;
   logic [1:0]  w_nextDone;
   logic        w_anyReq;
   logic        w_tieWinner;
   logic        w_sel;
   logic        w_grant;

   assign w_anyReq = bus.m0_req | bus.m1_req;
   assign w_sel    = (bus.m0_req && bus.m1_req) ? w_tieWinner : bus.m1_req;
   assign w_grant  = (r_state == ST_IDLE) && w_anyReq;

`ifdef REG_ARB_FIXED_PRIO_EN
   assign w_tieWinner = 1'b0;
`else
   logic r_lastGrant;

   // Remembers the most recent winner so a tie goes to the other master; resets to m1 so m0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lastGrant <= 1'b1;
      end else if (w_grant) begin
         r_lastGrant <= w_sel;
      end
   end

   assign w_tieWinner = ~r_lastGrant;
`endif

   // Next-state and next-output logic; every output is registered so it is computed one cycle early here.
   always_comb begin
      w_nextState   = r_state;
      w_nextCnt     = r_cnt;
      w_nextWinner  = r_winner;
      w_nextAddress = '0;
      w_nextWdata   = '0;
      w_nextXfc     = 1'b0;
      w_nextGnt     = 2'b00;
      w_nextDone    = 2'b00;
      case (r_state)
         ST_IDLE: begin
            if (w_anyReq) begin
               w_nextState   = ST_XFER;
               w_nextCnt     = XFC_LOAD;
               w_nextWinner  = w_sel;
               w_nextAddress = w_sel ? bus.m1_address : bus.m0_address;
               w_nextWdata   = w_sel ? bus.m1_wdata : bus.m0_wdata;
               w_nextXfc     = 1'b1;
               w_nextGnt     = w_sel ? 2'b10 : 2'b01;
            end
         end
         ST_XFER: begin
            if (r_cnt == 4'd0) begin
               w_nextState = ST_DONE;
               w_nextCnt   = GAP_LOAD;
               w_nextDone  = r_winner ? 2'b10 : 2'b01;
            end else begin
               w_nextCnt     = r_cnt - 4'd1;
               w_nextXfc     = 1'b1;
               w_nextAddress = r_address;
               w_nextWdata   = r_wdata;
            end
         end
         ST_DONE: begin
            w_nextState = ST_GAP;
         end
         ST_GAP: begin
            if (r_cnt == 4'd0) begin
               w_nextState = ST_IDLE;
            end else begin
               w_nextCnt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // State and output registers; an async reset aborts any write in flight without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_winner  <= 1'b0;
         r_address <= '0;
         r_wdata   <= '0;
         r_xfc     <= 1'b0;
         r_busy    <= 1'b0;
         r_gnt     <= 2'b00;
         r_done    <= 2'b00;
      end else begin
         r_state   <= w_nextState;
         r_cnt     <= w_nextCnt;
         r_winner  <= w_nextWinner;
         r_address <= w_nextAddress;
         r_wdata   <= w_nextWdata;
         r_xfc     <= w_nextXfc;
         r_busy    <= (w_nextState != ST_IDLE);
         r_gnt     <= w_nextGnt;
         r_done    <= w_nextDone;
      end
   end

   assign bus.m0_gnt  = r_gnt[0];
   assign bus.m1_gnt  = r_gnt[1];
   assign bus.m0_done = r_done[0];
   assign bus.m1_done = r_done[1];
   assign bus.address = r_address;
   assign bus.wdata   = r_wdata;
   assign bus.xfc     = r_xfc;
   assign bus.busy    = r_busy;

endmodule
